// File: rtl/kmu_block_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : kmu_block_sched_pkg                                           |
// | Description : Shared types for the KMU block scheduler: 3-D dimension       |
// |               vector, captured launch descriptor and scheduler state enum.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package kmu_block_sched_pkg;

   localparam int DIM_W = 32;   // width of each grid/block dimension and index
   localparam int XLEN  = 32;   // width of pc and kernel argument pointer

   // Index [0] is x, [1] is y, [2] is z.
   typedef logic [2:0][DIM_W-1:0] kmu_dim3_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] param;
      kmu_dim3_t       grid_dim;
      kmu_dim3_t       block_dim;
   } kmu_launch_t;

   typedef enum logic [1:0] {
      KMU_SCHED_IDLE     = 2'd0,
      KMU_SCHED_DISPATCH = 2'd1,
      KMU_SCHED_DRAIN    = 2'd2
   } kmu_sched_state_e;

   // An empty grid in any axis means the launch has no blocks at all.
   function automatic logic kmu_dim3_any_zero(input kmu_dim3_t d);
      return (d[0] == '0) || (d[1] == '0) || (d[2] == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/kmu_rr_select.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : kmu_rr_select                                                 |
// | Description : Combinational round-robin selector. Grants the first set      |
// |               request at or after ptr, wrapping around to index 0.          |
// | Ports       : req   - request vector                                        |
// |               ptr   - highest-priority index                                |
// |               grant - one-hot grant (all-zero when no request)              |
// |               valid - some request was granted                              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module kmu_rr_select
   import kmu_block_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               valid
);

   // Two passes: first look only at indices >= ptr, then fall back to the
   // lowest set request, which is the wrap-around part of the rotation.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!valid && req[i] && (i >= int'(ptr))) begin
            grant[i] = 1'b1;
            valid    = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!valid && req[i]) begin
            grant[i] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/kmu_block_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : kmu_block_sched                                               |
// | Description : Kernel block scheduler. Captures a launch descriptor on       |
// |               start, walks the 3-D grid x-fastest and offers each block to  |
// |               one core round-robin, limiting blocks in flight per core.     |
// | Ports       : clk, reset (async, active-low)                                |
// |               start, pc_in, param_in, grid_dim_in, block_dim_in - launch    |
// |               disp_valid/disp_ready - per-core dispatch handshake           |
// |               disp_pc, disp_param, disp_block_id, disp_block_dim - payload  |
// |               block_done - per-core completion pulse                        |
// |               busy - launch in progress; done - completion pulse            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module kmu_block_sched
   import kmu_block_sched_pkg::*;
#(
   parameter int NUM_TARGETS      = 4,
   parameter int MAX_OUTSTANDING  = 2,
   parameter bit CHECK_STRAY_DONE = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [XLEN-1:0]        pc_in,
   input  logic [XLEN-1:0]        param_in,
   input  logic [2:0][DIM_W-1:0]  grid_dim_in,
   input  logic [2:0][DIM_W-1:0]  block_dim_in,
   output logic [NUM_TARGETS-1:0] disp_valid,
   input  logic [NUM_TARGETS-1:0] disp_ready,
   output logic [XLEN-1:0]        disp_pc,
   output logic [XLEN-1:0]        disp_param,
   output logic [2:0][DIM_W-1:0]  disp_block_id,
   output logic [2:0][DIM_W-1:0]  disp_block_dim,
   input  logic [NUM_TARGETS-1:0] block_done,
   output logic                   busy,
   output logic                   done
);

   localparam int c_ptr_w = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [c_cnt_w-1:0] c_max_cnt  = c_cnt_w'(MAX_OUTSTANDING);
   localparam logic [c_ptr_w-1:0] c_last_tgt = c_ptr_w'(NUM_TARGETS - 1);

   kmu_sched_state_e       r_state, w_state_nxt;
   kmu_launch_t            r_launch;
   kmu_dim3_t              r_block_id, w_block_id_nxt;
   logic [c_ptr_w-1:0]     r_rr_ptr, w_grant_idx, w_rr_ptr_nxt;
   logic [NUM_TARGETS-1:0] w_eligible, w_grant, w_cnt_zero;
   logic                   w_fire, w_last_block, w_drain_exit, w_start_ok;
   logic                   r_busy, r_done;

   // ---------------------------------------------------------------- per core
   for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_tgt
      logic [c_cnt_w-1:0] r_out_cnt;

      assign w_eligible[i] = (r_state == KMU_SCHED_DISPATCH) && disp_ready[i] &&
                             (r_out_cnt < c_max_cnt);
      assign w_cnt_zero[i] = (r_out_cnt == '0);

      // A grant and a completion in the same cycle cancel out. A completion
      // against an empty counter is dropped, which also absorbs stale pulses
      // from cores that were mid-block when reset hit.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_out_cnt <= '0;
         end else if (w_grant[i] && !block_done[i]) begin
            r_out_cnt <= r_out_cnt + c_cnt_w'(1);
         end else if (!w_grant[i] && block_done[i] && (r_out_cnt != '0)) begin
            r_out_cnt <= r_out_cnt - c_cnt_w'(1);
         end
      end

      if (CHECK_STRAY_DONE) begin : g_stray_chk
         always @(posedge clk) begin
            if (reset && block_done[i] && !w_grant[i]) begin
               assert (r_out_cnt != '0);
            end
         end
      end
   end

   // ---------------------------------------------------------------- selection
   kmu_rr_select #(
      .NUM_REQ (NUM_TARGETS),
      .PTR_W   (c_ptr_w)
   ) u_rr_select (
      .req   (w_eligible),
      .ptr   (r_rr_ptr),
      .grant (w_grant),
      .valid (w_fire)
   );

   always_comb begin
      w_grant_idx = '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (w_grant[i]) begin
            w_grant_idx = c_ptr_w'(i);
         end
      end
      w_rr_ptr_nxt = (w_grant_idx == c_last_tgt) ? '0 : (w_grant_idx + c_ptr_w'(1));
   end

   // ---------------------------------------------------------------- index walker
   always_comb begin
      logic w_last_x, w_last_y, w_last_z;
      w_last_x = (r_block_id[0] == (r_launch.grid_dim[0] - DIM_W'(1)));
      w_last_y = (r_block_id[1] == (r_launch.grid_dim[1] - DIM_W'(1)));
      w_last_z = (r_block_id[2] == (r_launch.grid_dim[2] - DIM_W'(1)));
      w_last_block   = w_last_x && w_last_y && w_last_z;
      w_block_id_nxt = r_block_id;
      if (!w_last_x) begin
         w_block_id_nxt[0] = r_block_id[0] + DIM_W'(1);
      end else begin
         w_block_id_nxt[0] = '0;
         if (!w_last_y) begin
            w_block_id_nxt[1] = r_block_id[1] + DIM_W'(1);
         end else begin
            w_block_id_nxt[1] = '0;
            w_block_id_nxt[2] = r_block_id[2] + DIM_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   assign w_start_ok   = (r_state == KMU_SCHED_IDLE) && start;
   // A completion still arriving this cycle means a core is not yet quiet.
   assign w_drain_exit = (r_state == KMU_SCHED_DRAIN) && (&w_cnt_zero) && (block_done == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= KMU_SCHED_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         KMU_SCHED_IDLE: begin
            if (start) begin
               w_state_nxt = kmu_dim3_any_zero(grid_dim_in) ? KMU_SCHED_DRAIN
                                                             : KMU_SCHED_DISPATCH;
            end
         end
         KMU_SCHED_DISPATCH: begin
            if (w_fire && w_last_block) begin
               w_state_nxt = KMU_SCHED_DRAIN;
            end
         end
         KMU_SCHED_DRAIN: begin
            if (w_drain_exit) begin
               w_state_nxt = KMU_SCHED_IDLE;
            end
         end
         default: w_state_nxt = KMU_SCHED_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_launch   <= '0;
         r_block_id <= '0;
         r_rr_ptr   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_launch   <= '{pc: pc_in, param: param_in,
                            grid_dim: grid_dim_in, block_dim: block_dim_in};
            r_block_id <= '0;
            r_busy     <= 1'b1;
         end
         if (w_fire) begin
            r_rr_ptr <= w_rr_ptr_nxt;
            // The final index is held rather than wrapped back to zero.
            if (!w_last_block) begin
               r_block_id <= w_block_id_nxt;
            end
         end
         if (w_drain_exit) begin
            r_busy <= 1'b0;
         end
         r_done <= w_drain_exit;
      end
   end

   assign disp_valid     = w_grant;
   assign disp_pc        = r_launch.pc;
   assign disp_param     = r_launch.param;
   assign disp_block_dim = r_launch.block_dim;
   assign disp_block_id  = r_block_id;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_kmu_block_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_kmu_block_sched                                            |
// | Description : Self-checking bench for kmu_block_sched. A launch-level model |
// |               (queue of expected block ids, per-core in-flight counts,      |
// |               round-robin pointer) predicts every output each cycle.        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_kmu_block_sched;
   import kmu_block_sched_pkg::*;

   localparam int N    = 4;
   localparam int MAXO = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  start = 1'b0;
   logic [XLEN-1:0]       pc_in = '0;
   logic [XLEN-1:0]       param_in = '0;
   logic [2:0][DIM_W-1:0] grid_dim_in = '0;
   logic [2:0][DIM_W-1:0] block_dim_in = '0;
   logic [N-1:0]          disp_valid;
   logic [N-1:0]          disp_ready = '0;
   logic [XLEN-1:0]       disp_pc, disp_param;
   logic [2:0][DIM_W-1:0] disp_block_id, disp_block_dim;
   logic [N-1:0]          block_done = '0;
   logic                  busy, done;

   always #5 clk = ~clk;

   kmu_block_sched #(
      .NUM_TARGETS      (N),
      .MAX_OUTSTANDING  (MAXO),
      .CHECK_STRAY_DONE (1'b0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .pc_in          (pc_in),
      .param_in       (param_in),
      .grid_dim_in    (grid_dim_in),
      .block_dim_in   (block_dim_in),
      .disp_valid     (disp_valid),
      .disp_ready     (disp_ready),
      .disp_pc        (disp_pc),
      .disp_param     (disp_param),
      .disp_block_id  (disp_block_id),
      .disp_block_dim (disp_block_dim),
      .block_done     (block_done),
      .busy           (busy),
      .done           (done)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int obs_fires, obs_done, obs_first_fire, obs_last_fire, obs_done_cyc;

   // Launch-level model: 0 = no launch, 1 = blocks left to hand out, 2 = waiting for cores.
   int          m_phase;
   bit          m_busy, m_done;
   logic [31:0] m_pc, m_param;
   logic [95:0] m_bdim;
   int          m_cnt[N];
   int          m_rr;
   logic [95:0] m_q[$];
   logic [N-1:0] m_last_grant;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_busy = 0; m_done = 0;
      m_pc = '0; m_param = '0; m_bdim = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0;
      m_q.delete();
      m_last_grant = '0;
   endtask

   // First core at or after the pointer that is ready and has room.
   function automatic logic [N-1:0] m_grant();
      if (m_phase != 1) return '0;
      for (int k = 0; k < N; k++) begin
         int i = (m_rr + k) % N;
         if (disp_ready[i] && (m_cnt[i] < MAXO)) return N'(1) << i;
      end
      return '0;
   endfunction

   task automatic model_step(input logic [N-1:0] g);
      int ph = m_phase;
      bit all_zero = 1;
      bit drain_exit;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all_zero = 0;
      drain_exit = (ph == 2) && all_zero && (block_done == '0);
      for (int i = 0; i < N; i++) begin
         if (g[i] && !block_done[i]) m_cnt[i]++;
         else if (!g[i] && block_done[i] && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (g != '0) begin
         for (int i = 0; i < N; i++) if (g[i]) m_rr = (i + 1) % N;
         void'(m_q.pop_front());
         if (m_q.size() == 0) m_phase = 2;
      end
      if (drain_exit) begin
         m_phase = 0;
         m_busy  = 0;
      end
      if (ph == 0 && start) begin
         m_pc = pc_in; m_param = param_in; m_bdim = block_dim_in;
         m_q.delete();
         for (int z = 0; z < int'(grid_dim_in[2]); z++)
            for (int y = 0; y < int'(grid_dim_in[1]); y++)
               for (int x = 0; x < int'(grid_dim_in[0]); x++)
                  m_q.push_back({32'(z), 32'(y), 32'(x)});
         m_busy  = 1;
         m_phase = (m_q.size() == 0) ? 2 : 1;
      end
      m_done       = drain_exit;
      m_last_grant = g;
   endtask

   // mode 0: random ready/completions, 1: only core 0 ready with completion one
   // cycle after each grant, 2: inputs left as the caller set them.
   task automatic tick(input int mode);
      logic [N-1:0] g;
      if (mode == 0) begin
         for (int i = 0; i < N; i++) begin
            disp_ready[i] = ($urandom_range(0, 3) != 0);
            block_done[i] = (m_cnt[i] > 0) && ($urandom_range(0, 2) == 0);
         end
      end else if (mode == 1) begin
         disp_ready = 4'b0001;
         block_done = m_last_grant;
      end
      @(negedge clk);
      g = m_grant();
      chk("disp_valid", 96'(disp_valid), 96'(g));
      if (g != '0) chk("block_id", disp_block_id, m_q[0]);
      chk("busy", 96'(busy), 96'(m_busy));
      chk("done", 96'(done), 96'(m_done));
      chk("disp_pc", 96'(disp_pc), 96'(m_pc));
      chk("disp_param", 96'(disp_param), 96'(m_param));
      chk("block_dim", disp_block_dim, m_bdim);
      if (disp_valid != '0) begin
         if (obs_fires == 0) obs_first_fire = cyc;
         obs_last_fire = cyc;
         obs_fires++;
      end
      if (done === 1'b1) begin
         obs_done++;
         obs_done_cyc = cyc;
      end
      model_step(g);
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
   endtask

   task automatic run_until_idle(input int mode, input int budget);
      int n = 0;
      while ((m_busy || m_done) && n < budget) begin
         tick(mode);
         n++;
      end
      chk("cycle_budget", 96'(n >= budget), 96'(0));
   endtask

   task automatic launch(input int gx, input int gy, input int gz, input int mode);
      pc_in        = $urandom;
      param_in     = $urandom;
      grid_dim_in  = {32'(gz), 32'(gy), 32'(gx)};
      block_dim_in = {32'($urandom_range(1, 8)), 32'($urandom_range(1, 8)), 32'($urandom_range(1, 64))};
      start        = 1'b1;
      tick(mode);
   endtask

   task automatic clear_obs();
      obs_fires = 0; obs_done = 0; obs_first_fire = -1; obs_last_fire = -1; obs_done_cyc = -1;
   endtask

   initial begin
      int s, pc_a, gx, gy, gz;
      model_reset();
      clear_obs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 96'(disp_valid), 96'(0));
      chk("rst_busy", 96'(busy), 96'(0));
      chk("rst_done", 96'(done), 96'(0));
      chk("rst_pc", 96'(disp_pc), 96'(0));
      chk("rst_block_id", disp_block_id, 96'(0));
      reset = 1'b1;
      tick(2);

      // Four ready cores, no completions: grants rotate 0..3, then busy holds in drain.
      clear_obs();
      disp_ready = 4'hF; block_done = '0;
      launch(4, 1, 1, 2);
      repeat (8) tick(2);
      chk("s2_fires", 96'(obs_fires), 96'(4));
      chk("s2_busy_in_drain", 96'(busy), 96'(1));
      block_done = 4'hF;
      tick(2);
      block_done = '0;
      run_until_idle(2, 20);
      chk("s2_done_cnt", 96'(obs_done), 96'(1));

      // One core, completion one cycle after each grant: six blocks back to back.
      clear_obs();
      s = cyc;
      launch(3, 2, 1, 1);
      run_until_idle(1, 40);
      chk("s1_fires", 96'(obs_fires), 96'(6));
      chk("s1_first_fire", 96'(obs_first_fire), 96'(s + 1));
      chk("s1_consecutive", 96'(obs_last_fire - obs_first_fire), 96'(5));
      chk("s1_done_cnt", 96'(obs_done), 96'(1));

      // One core, completions withheld: stops at two in flight.
      clear_obs();
      disp_ready = 4'b0001; block_done = '0;
      launch(5, 1, 1, 2);
      repeat (5) tick(2);
      chk("s3_limit", 96'(obs_fires), 96'(2));
      block_done = 4'b0001;
      tick(2);
      block_done = '0;
      repeat (3) tick(2);
      chk("s3_reenable", 96'(obs_fires), 96'(3));
      run_until_idle(0, 500);

      // Empty grid: no offers, done two cycles after start.
      clear_obs();
      s = cyc;
      launch(0, 5, 5, 0);
      run_until_idle(0, 20);
      chk("s4_no_fire", 96'(obs_fires), 96'(0));
      chk("s4_done_lat", 96'(obs_done_cyc - s), 96'(2));
      chk("s4_done_cnt", 96'(obs_done), 96'(1));

      // Second start while busy is ignored.
      clear_obs();
      launch(3, 3, 1, 0);
      pc_a = int'(pc_in);
      repeat (3) tick(0);
      pc_in = ~pc_in; param_in = ~param_in;
      grid_dim_in = {32'(2), 32'(2), 32'(2)};
      start = 1'b1;
      tick(0);
      chk("s5_pc_held", 96'(disp_pc), 96'(32'(pc_a)));
      run_until_idle(0, 500);
      chk("s5_fires", 96'(obs_fires), 96'(9));

      // Reset mid-dispatch, stray completions afterwards, then a clean launch.
      launch(4, 4, 1, 0);
      repeat (4) tick(0);
      reset = 1'b0;
      #1;
      model_reset();
      chk("s6_valid", 96'(disp_valid), 96'(0));
      chk("s6_busy", 96'(busy), 96'(0));
      chk("s6_done", 96'(done), 96'(0));
      chk("s6_pc", 96'(disp_pc), 96'(0));
      chk("s6_param", 96'(disp_param), 96'(0));
      chk("s6_block_id", disp_block_id, 96'(0));
      chk("s6_block_dim", disp_block_dim, 96'(0));
      repeat (2) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      reset = 1'b1;
      disp_ready = '0; block_done = 4'hF;
      tick(2);
      block_done = '0;
      tick(2);
      clear_obs();
      launch(2, 2, 2, 0);
      run_until_idle(0, 500);
      chk("s6_fires", 96'(obs_fires), 96'(8));
      chk("s6_done_cnt", 96'(obs_done), 96'(1));

      // Random launches.
      for (int r = 0; r < 6; r++) begin
         clear_obs();
         gx = $urandom_range(1, 4);
         gy = $urandom_range(1, 3);
         gz = $urandom_range(1, 2);
         launch(gx, gy, gz, 0);
         run_until_idle(0, 1000);
         chk("rnd_fires", 96'(obs_fires), 96'(gx * gy * gz));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
